// File: rtl/set_bit_walker_pkg.sv
// Shared types and width helpers for set_bit_walker.
// Optional feature macro: SET_BIT_WALKER_COUNT_EN (adds out_count).
package set_bit_walker_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } walker_state_t;

    // Width of a binary index into a word of w bits.
    function automatic int index_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

`ifdef SET_BIT_WALKER_COUNT_EN
    // Width of a 1-based beat ordinal, which can reach w.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction
`endif

endpackage

// File: rtl/set_bit_walker_onehot_to_index.sv
// Combinational one-hot to binary encoder; an all-zero input gives index 0.
module onehot_to_index
    import set_bit_walker_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    localparam int IW = index_width(WORD_WIDTH)
) (
    input  logic [WORD_WIDTH-1:0] onehot_i,
    output logic [IW-1:0]         index_o
);

    // OR together the positions of every set bit (exactly one for a valid one-hot).
    always_comb begin
        index_o = '0;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            if (onehot_i[i]) begin
                index_o = index_o | IW'(i);
            end
        end
    end

endmodule

// File: rtl/set_bit_walker.sv
// Drains the set bits of an accepted word, one per beat, senior- or junior-first.
// Optional feature macro: SET_BIT_WALKER_COUNT_EN (adds out_count beat ordinal).
module set_bit_walker
    import set_bit_walker_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    localparam int IW = index_width(WORD_WIDTH)
`ifdef SET_BIT_WALKER_COUNT_EN
    ,
    localparam int CW = count_width(WORD_WIDTH)
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_word,
    input  logic                  in_senior_first,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_onehot,
    output logic [IW-1:0]         out_index,
    output logic                  out_last,
    output logic                  out_zero,
`ifdef SET_BIT_WALKER_COUNT_EN
    output logic [CW-1:0]         out_count,
`endif
    output logic                  busy
);

    walker_state_t         state_q, state_d;
    logic [WORD_WIDTH-1:0] rem_q, rem_d;
    logic                  order_q, order_d;
`ifdef SET_BIT_WALKER_COUNT_EN
    logic [CW-1:0]         count_q, count_d;
`endif

    logic [WORD_WIDTH-1:0] rem_rev, rev_iso, senior_iso, junior_iso, sel_iso;
    logic                  walking, multi_bit;

    // Isolate the junior-most bit directly and the senior-most bit via bit reversal.
    always_comb begin
        rem_rev    = '0;
        senior_iso = '0;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            rem_rev[i] = rem_q[WORD_WIDTH-1-i];
        end
        junior_iso = rem_q & (~rem_q + WORD_WIDTH'(1));
        rev_iso    = rem_rev & (~rem_rev + WORD_WIDTH'(1));
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            senior_iso[i] = rev_iso[WORD_WIDTH-1-i];
        end
        sel_iso   = order_q ? senior_iso : junior_iso;
        multi_bit = |(rem_q & (rem_q - WORD_WIDTH'(1)));
    end

    assign walking    = (state_q == WALK);
    assign in_ready   = !walking;
    assign out_valid  = walking;
    assign busy       = walking;
    assign out_onehot = walking ? sel_iso : '0;
    // A zero remainder in WALK can only come from an all-zero input word.
    assign out_last   = walking && !multi_bit;
    assign out_zero   = walking && (rem_q == '0);
`ifdef SET_BIT_WALKER_COUNT_EN
    assign out_count  = count_q;
`endif

    onehot_to_index #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_enc (
        .onehot_i (out_onehot),
        .index_o  (out_index)
    );

    // Next-state: capture on accept, clear emitted bit on each consumed beat.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        order_d = order_q;
`ifdef SET_BIT_WALKER_COUNT_EN
        count_d = count_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = in_word;
                    order_d = in_senior_first;
                    state_d = WALK;
`ifdef SET_BIT_WALKER_COUNT_EN
                    count_d = (in_word != '0) ? CW'(1) : '0;
`endif
                end
            end
            WALK: begin
                if (out_ready) begin
                    rem_d = rem_q & ~sel_iso;
                    if (out_last) begin
                        state_d = IDLE;
                    end
`ifdef SET_BIT_WALKER_COUNT_EN
                    count_d = out_last ? '0 : count_q + CW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            order_q <= 1'b0;
`ifdef SET_BIT_WALKER_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            order_q <= order_d;
`ifdef SET_BIT_WALKER_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

endmodule

// File: tb/tb_set_bit_walker.sv
// Self-checking bench for set_bit_walker against a list-based beat model.
module tb_set_bit_walker;

    localparam int W  = 8;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_senior_first, out_ready;
    logic [W-1:0]  in_word;
    logic          in_ready, out_valid, out_last, out_zero, busy;
    logic [W-1:0]  out_onehot;
    logic [IW-1:0] out_index;
`ifdef SET_BIT_WALKER_COUNT_EN
    logic [CW-1:0] out_count;
`endif

    set_bit_walker #(.WORD_WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_word         (in_word),
        .in_senior_first (in_senior_first),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_onehot      (out_onehot),
        .out_index       (out_index),
        .out_last        (out_last),
        .out_zero        (out_zero),
`ifdef SET_BIT_WALKER_COUNT_EN
        .out_count       (out_count),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic          rdy;
        logic          busy;
        logic [W-1:0]  onehot;
        logic [IW-1:0] index;
        logic          last;
        logic          zero;
        logic [CW-1:0] count;
    } obs_t;

    localparam obs_t IDLE_OBS = '{valid: 1'b0, rdy: 1'b1, busy: 1'b0, onehot: '0,
                                   index: '0, last: 1'b0, zero: 1'b0, count: '0};

    int   vectors = 0;
    int   miscompares = 0;
    obs_t exp_q[$];
    obs_t obs_q[$];
    int   lat, stall_changes, timed_out;
    obs_t post;

    function automatic obs_t sample();
        obs_t s;
        s.valid  = out_valid;
        s.rdy    = in_ready;
        s.busy   = busy;
        s.onehot = out_onehot;
        s.index  = out_index;
        s.last   = out_last;
        s.zero   = out_zero;
`ifdef SET_BIT_WALKER_COUNT_EN
        s.count  = out_count;
`else
        s.count  = '0;
`endif
        return s;
    endfunction

    // Expected beats: list set-bit positions in the requested order.
    task automatic build_model(input logic [W-1:0] word, input logic senior);
        int   pos[$];
        obs_t b;
        exp_q.delete();
        for (int k = 0; k < W; k++) begin
            int p;
            p = senior ? (W - 1 - k) : k;
            if (word[p]) pos.push_back(p);
        end
        if (pos.size() == 0) begin
            b = '{valid: 1'b1, rdy: 1'b0, busy: 1'b1, onehot: '0, index: '0,
                  last: 1'b1, zero: 1'b1, count: '0};
            exp_q.push_back(b);
        end
        for (int n = 0; n < pos.size(); n++) begin
            b.valid  = 1'b1;
            b.rdy    = 1'b0;
            b.busy   = 1'b1;
            b.onehot = W'(1) << pos[n];
            b.index  = IW'(pos[n]);
            b.last   = (n == pos.size() - 1);
            b.zero   = 1'b0;
`ifdef SET_BIT_WALKER_COUNT_EN
            b.count  = CW'(n + 1);
`else
            b.count  = '0;
`endif
            exp_q.push_back(b);
        end
    endtask

    // Drive one word through the DUT and record the accepted beats; starts and ends on a negedge.
    task automatic run_word(input logic [W-1:0] word, input logic senior,
                            input bit rand_ready, input bit noise);
        obs_t snap, prev;
        bit   prev_stalled;
        bit   r;
        int   cycles;
        obs_q.delete();
        stall_changes = 0;
        timed_out = 0;
        prev_stalled = 1'b0;
        prev = '0;
        in_valid = 1'b1;
        in_word = word;
        in_senior_first = senior;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = noise ? 1'($urandom) : 1'b0;
        in_word = W'($urandom);
        in_senior_first = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        cycles = 0;
        forever begin
            snap = sample();
            if (prev_stalled && snap !== prev) stall_changes++;
            r = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            out_ready = r;
            if (noise) begin
                in_valid = 1'($urandom);
                in_word = W'($urandom);
                in_senior_first = 1'($urandom);
            end
            if (r) obs_q.push_back(snap);
            prev = snap;
            prev_stalled = !r;
            @(negedge clk);
            cycles++;
            if (r && snap.last) break;
            if (cycles > 400) begin
                timed_out = 1;
                break;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        post = sample();
    endtask

    // One word scenario with every observation compared against the model.
    task automatic check_walk(input string name, input logic [W-1:0] word, input logic senior,
                              input bit rand_ready, input bit noise);
        build_model(word, senior);
        run_word(word, senior, rand_ready, noise);
        vectors++;
        if (timed_out != 0) begin
            miscompares++;
            $display("FAIL %s timeout: word %h got %0d beats without last", name, word, obs_q.size());
        end
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL %s latency: got %0d required 1", name, lat);
        end
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL %s beat_count: word %h got %0d required %0d", name, word, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s beat%0d: word %h got %h required %h", name, i, word, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (stall_changes !== 0) begin
            miscompares++;
            $display("FAIL %s stall_stability: got %0d changes required 0", name, stall_changes);
        end
        vectors++;
        if (post !== IDLE_OBS) begin
            miscompares++;
            $display("FAIL %s return_idle: got %h required %h", name, post, IDLE_OBS);
        end
    endtask

    task automatic test_reset();
        obs_t s;
        rst = 1'b1;
        in_valid = 1'b1;
        in_word = 8'hFF;
        in_senior_first = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        s = sample();
        vectors++;
        if (s !== IDLE_OBS) begin
            miscompares++;
            $display("FAIL reset_state: got %h required %h", s, IDLE_OBS);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        s = sample();
        vectors++;
        if (s !== IDLE_OBS) begin
            miscompares++;
            $display("FAIL reset_release: got %h required %h", s, IDLE_OBS);
        end
    endtask

    task automatic test_junior_walk();
        check_walk("junior_a6", 8'hA6, 1'b0, 1'b0, 1'b0);
        check_walk("junior_01", 8'h01, 1'b0, 1'b0, 1'b0);
        check_walk("junior_80", 8'h80, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_senior_walk();
        check_walk("senior_a6", 8'hA6, 1'b1, 1'b0, 1'b0);
        check_walk("senior_ff", 8'hFF, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_word();
        check_walk("zero_lsb", 8'h00, 1'b0, 1'b0, 1'b0);
        check_walk("zero_msb", 8'h00, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        check_walk("bp_ff_lsb", 8'hFF, 1'b0, 1'b1, 1'b1);
        check_walk("bp_ff_msb", 8'hFF, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            check_walk("bp_random", W'($urandom), 1'($urandom), 1'b1, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            check_walk("b2b_random", W'($urandom), 1'($urandom), 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_midwalk();
        obs_t s;
        in_valid = 1'b1;
        in_word = 8'h0F;
        in_senior_first = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        s = sample();
        vectors++;
        if (s.onehot !== 8'h04 || s.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midwalk_third_beat: got onehot %h valid %b required 04 1", s.onehot, s.valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s = sample();
        vectors++;
        if (s !== IDLE_OBS) begin
            miscompares++;
            $display("FAIL midwalk_reset: got %h required %h", s, IDLE_OBS);
        end
        @(negedge clk);
        s = sample();
        vectors++;
        if (s !== IDLE_OBS) begin
            miscompares++;
            $display("FAIL midwalk_quiet: got %h required %h", s, IDLE_OBS);
        end
        out_ready = 1'b0;
        check_walk("after_reset_0f", 8'h0F, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef SET_BIT_WALKER_COUNT_EN
    task automatic test_count();
        run_word(8'h11, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (obs_q.size() !== 2 || obs_q[0].count !== CW'(1) || obs_q[1].count !== CW'(2)) begin
            miscompares++;
            $display("FAIL count_11: got %0d beats, counts %p required 2 beats 1,2", obs_q.size(), obs_q);
        end
        run_word(8'h00, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (obs_q.size() !== 1 || obs_q[0].count !== '0) begin
            miscompares++;
            $display("FAIL count_zero: got %0d beats first %h required 1 beat count 0", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_word = '0;
        in_senior_first = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_junior_walk();
        test_senior_walk();
        test_zero_word();
        test_backpressure();
        test_back_to_back();
        test_reset_midwalk();
`ifdef SET_BIT_WALKER_COUNT_EN
        test_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
